i2c_scan_ctrl: RTL

Sequences the single-address I2C presence probe across a configurable 7-bit address range. Issues one probe per address and records each ACK/NAK into a 128-entry presence bitmap, with a running device count. Streams found addresses to a consumer over a valid/ready port. Sits between a host/CSR layer and the probe, which owns the I2C master and 3-state pins.

---
 rtl/i2c_scan_pkg.sv | 21 ++
 rtl/i2c_scan_bitmap.sv | 32 +++
 rtl/i2c_scan_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/i2c_scan_pkg.sv
// Shared types and constants for the I2C address-range scanner.
// Pure declarations: no latency and no backpressure apply.
package i2c_scan_pkg;

    localparam int I2C_ADR_W = 7;
    localparam int I2C_TMO_W = 20;

    localparam logic [I2C_ADR_W-1:0] I2C_RESERVED_LO = 7'h08;
    localparam logic [I2C_ADR_W-1:0] I2C_RESERVED_HI = 7'h77;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_NEXT,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/i2c_scan_bitmap.sv
// 128x1 presence bitmap: single-cycle clear-all, one write port, one registered read port.
// Read latency 1 cycle, returning the pre-write contents; no backpressure.
module i2c_scan_bitmap
    import i2c_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [I2C_ADR_W-1:0] wr_adr,
    input  logic                 wr_dat,
    input  logic [I2C_ADR_W-1:0] rd_adr,
    output logic                 rd_dat
);

    logic [(2**I2C_ADR_W)-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            rd_dat <= 1'b0;
        end else begin
            if (clr) begin
                mem <= '0;
            end else if (wr_en) begin
                mem[wr_adr] <= wr_dat;
            end
            rd_dat <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/i2c_scan_ctrl.sv
// Scans ADR_LO..ADR_HI with one probe per address; bitmap, count, result stream; first probe 2 cycles after start.
// Stalls in EMIT until res_ready; I2C_SCAN_RETRY_EN adds one re-probe after a NAK or timeout.
module i2c_scan_ctrl
    import i2c_scan_pkg::*;
#(
    parameter logic [I2C_ADR_W-1:0] ADR_LO     = I2C_RESERVED_LO,
    parameter logic [I2C_ADR_W-1:0] ADR_HI     = I2C_RESERVED_HI,
    parameter logic [I2C_TMO_W-1:0] TIMEOUT    = 20'd100000,
    parameter logic                 REPORT_NAK = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           found_cnt,
    output logic                 prb_stb,
    output logic [I2C_ADR_W-1:0] prb_adr,
    input  logic                 prb_bsy,
    input  logic                 prb_ostb,
    input  logic                 prb_ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [I2C_ADR_W-1:0] res_adr,
    output logic                 res_ack,
    input  logic [I2C_ADR_W-1:0] rd_adr,
    output logic                 rd_ack
);

    scan_state_t            state_q, state_d;
    logic [I2C_ADR_W-1:0]   cur_adr;
    logic [I2C_TMO_W-1:0]   tmo_cnt;
    logic                   ack_q;

    logic                   bm_clr;
    logic                   rec;
    logic                   load_tmo;
    logic                   wait_end;
    logic                   wait_ack;
    logic                   tmo_expired;
`ifdef I2C_SCAN_RETRY_EN
    logic                   retry_q;
    logic                   retry_set;
`endif

    // Expiring at a count of 1 gives exactly TIMEOUT cycles in WAIT per probe.
    assign tmo_expired = !prb_ostb && (tmo_cnt <= 20'd1);
    assign wait_end    = prb_ostb || tmo_expired;
    assign wait_ack    = prb_ostb && prb_ack;

    always_comb begin
        state_d  = state_q;
        bm_clr   = 1'b0;
        rec      = 1'b0;
        load_tmo = 1'b0;
`ifdef I2C_SCAN_RETRY_EN
        retry_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                bm_clr  = 1'b1;
                state_d = (ADR_LO > ADR_HI) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (!prb_bsy) begin
                    load_tmo = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_end) begin
                    rec = 1'b1;
`ifdef I2C_SCAN_RETRY_EN
                    if (!wait_ack && !retry_q) begin
                        rec       = 1'b0;
                        retry_set = 1'b1;
                    end
`endif
                    if (rec) begin
                        state_d = (wait_ack || REPORT_NAK) ? S_EMIT : S_NEXT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_EMIT: begin
                if (res_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                // Compare-based termination lets ADR_HI = 7'h7F stop without wrapping.
                state_d = (cur_adr == ADR_HI) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_adr   <= '0;
            found_cnt <= '0;
            err       <= 1'b0;
            ack_q     <= 1'b0;
            tmo_cnt   <= '0;
`ifdef I2C_SCAN_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && start) begin
                cur_adr   <= ADR_LO;
                found_cnt <= '0;
                err       <= 1'b0;
            end else if (state_q == S_NEXT && cur_adr != ADR_HI) begin
                cur_adr <= cur_adr + 7'd1;
            end

            if (load_tmo) begin
                tmo_cnt <= TIMEOUT;
            end else if (state_q == S_WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 20'd1;
            end

            if (state_q == S_WAIT && wait_end) begin
                ack_q <= wait_ack;
            end

            if (rec) begin
                if (wait_ack && found_cnt != 8'hFF) found_cnt <= found_cnt + 8'd1;
                if (tmo_expired) err <= 1'b1;
            end

`ifdef I2C_SCAN_RETRY_EN
            if (state_q == S_CLEAR || state_q == S_NEXT) begin
                retry_q <= 1'b0;
            end else if (retry_set) begin
                retry_q <= 1'b1;
            end
`endif
        end
    end

    i2c_scan_bitmap u_bitmap (
        .clk    (clk),
        .rst    (rst),
        .clr    (bm_clr),
        .wr_en  (rec),
        .wr_adr (cur_adr),
        .wr_dat (wait_ack),
        .rd_adr (rd_adr),
        .rd_dat (rd_ack)
    );

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    // Gated by rst so an abort in ISSUE cannot leak a strobe in the reset cycle.
    assign prb_stb   = (state_q == S_ISSUE) && !prb_bsy && !rst;
    assign prb_adr   = cur_adr;
    assign res_valid = (state_q == S_EMIT);
    assign res_adr   = cur_adr;
    assign res_ack   = ack_q;

endmodule
